// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Round-robin between ALU and LSU, plus a busy scoreboard for issue hazards.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_valid,
   input  logic [4:0]            iss_rd,
   input  logic [4:0]            iss_rs1,
   input  logic [4:0]            iss_rs2,
   output logic                  iss_stall,
   input  logic                  alu_valid,
   input  logic [4:0]            alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [4:0]            lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   output logic [4:0]            AD3,
   output logic                  WE3,
   output logic [DATA_WIDTH-1:0] WD3,
   output logic [31:0]           busy
);

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_LSU = 1'b1
   } grant_e;

   grant_e                last_grant;
   logic [31:0]           busy_q;
   logic [31:0]           busy_d;
   logic [31:0]           set_mask;
   logic [31:0]           clr_mask;
   logic                  xfer;
   logic [4:0]            wb_rd;
   logic [DATA_WIDTH-1:0] wb_data;

   always_comb begin
      alu_ready = alu_valid &&
                  (!lsu_valid || last_grant == GNT_LSU);
      lsu_ready = lsu_valid &&
                  (!alu_valid || last_grant == GNT_ALU);
      xfer      = alu_ready || lsu_ready;
      wb_rd     = lsu_ready ? lsu_rd : alu_rd;
      wb_data   = lsu_ready ? lsu_data : alu_data;

      // Stall uses registered busy only; no same-cycle bypass.
      iss_stall = iss_valid &&
                  (busy_q[iss_rs1] || busy_q[iss_rs2] ||
                   busy_q[iss_rd]);

      clr_mask = '0;
      if (xfer && wb_rd != 5'd0)
         clr_mask[wb_rd] = 1'b1;

      set_mask = '0;
      if (iss_valid && !iss_stall && iss_rd != 5'd0)
         set_mask[iss_rd] = 1'b1;

      // Set applied after clear so a same-edge set wins.
      busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'h1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         WE3        <= 1'b0;
         AD3        <= '0;
         WD3        <= '0;
         last_grant <= GNT_LSU;
      end else begin
         busy_q <= busy_d;
         WE3    <= xfer && wb_rd != 5'd0;
         if (xfer) begin
            AD3        <= wb_rd;
            WD3        <= wb_data;
            last_grant <= lsu_ready ? GNT_LSU : GNT_ALU;
         end
      end
   end

   assign busy = busy_q;

endmodule
